// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-lock sequencer.
// Provides the FSM state enum, digit type, CANCEL key value and state_o codes.
package lock_pkg;

    typedef logic [3:0] digit_t;

    localparam digit_t CANCEL_DIGIT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_PROGRAM  = 3'd4,
        ST_LOCKOUT  = 3'd5
    } lock_state_t;

    // Encodings seen on state_o
    localparam logic [2:0] STATE_O_IDLE     = 3'd0;
    localparam logic [2:0] STATE_O_ENTRY    = 3'd1;
    localparam logic [2:0] STATE_O_CHECK    = 3'd2;
    localparam logic [2:0] STATE_O_UNLOCKED = 3'd3;
    localparam logic [2:0] STATE_O_PROGRAM  = 3'd4;
    localparam logic [2:0] STATE_O_LOCKOUT  = 3'd5;

    function automatic int unsigned max4(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c,
                                         input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Shared down-counter for the lock sequencer's timed states.
// Ports: clk, rst (async active-low), load_i/load_val_i reload, expired_o when count is 0.
module lock_timer #(
    parameter int unsigned W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/lock_sequencer.sv
// Keypad code-lock control FSM: entry, compare, unlock hold, lockout, reprogram.
// Ports: clk, rst (async active-low), key_valid/key_digit, prog_req in;
//   unlock, locked_out, fail_pulse, prog_done, state_o out.
// Optional macro LOCK_AUDIT_EN adds fail_total[7:0], a saturating failure count.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN          = 4,
    parameter int unsigned MAX_FAIL          = 3,
    parameter int unsigned LOCKOUT_CYC       = 1024,
    parameter int unsigned UNLOCK_CYC        = 256,
    parameter int unsigned ENTRY_TO_CYC      = 4096,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       prog_req,
    output logic       unlock,
    output logic       locked_out,
    output logic       fail_pulse,
    output logic       prog_done,
    output logic [2:0] state_o
`ifdef LOCK_AUDIT_EN
    ,
    output logic [7:0] fail_total
`endif
);

    localparam int unsigned MAXD =
        max4(LOCKOUT_CYC, UNLOCK_CYC, ENTRY_TO_CYC, 2);
    localparam int unsigned TW   = $clog2(MAXD);
    localparam int unsigned IDX_W = $clog2(CODE_LEN);
    localparam int unsigned CW   = CODE_LEN * 4;

    // Timer is loaded with duration-1 so the state lasts exactly duration cycles
    localparam logic [TW-1:0] TO_V  = TW'(ENTRY_TO_CYC - 1);
    localparam logic [TW-1:0] UNL_V = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LCK_V = TW'(LOCKOUT_CYC - 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CODE_LEN - 1);
    localparam logic [3:0]       FMAX     = 4'(MAX_FAIL);

    lock_state_t      state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [CW-1:0]    shadow_q, shadow_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             mis_q, mis_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic [3:0]       fcnt_inc;
    logic             unlock_q, locked_q, fail_q, done_q;
    logic             fail_d, done_d;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_exp;
    digit_t           cur_digit;
    logic             is_digit;

    lock_timer #(.W(TW)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expired_o (tmr_exp)
    );

    assign cur_digit = code_q[4*int'(idx_q) +: 4];
    assign is_digit  = key_valid && (key_digit != CANCEL_DIGIT);

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fcnt_d   = fcnt_q;
        fcnt_inc = (fcnt_q >= FMAX) ? FMAX : fcnt_q + 4'd1;
        fail_d   = 1'b0;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TO_V;
        case (state_q)
            ST_IDLE: begin
                if (is_digit) begin
                    mis_d    = (key_digit != code_q[3:0]);
                    idx_d    = IDX_W'(1);
                    state_d  = ST_ENTRY;
                    tmr_load = 1'b1;
                end
            end
            ST_ENTRY: begin
                if (key_valid) begin
                    if (key_digit == CANCEL_DIGIT) begin
                        state_d = ST_IDLE;
                    end else begin
                        mis_d = mis_q | (key_digit != cur_digit);
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d    = idx_q + IDX_W'(1);
                            tmr_load = 1'b1;
                        end
                    end
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!mis_q) begin
                    fcnt_d   = 4'd0;
                    state_d  = ST_UNLOCKED;
                    tmr_load = 1'b1;
                    tmr_val  = UNL_V;
                end else begin
                    fail_d = 1'b1;
                    fcnt_d = fcnt_inc;
                    if (fcnt_inc == FMAX) begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = LCK_V;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UNLOCKED: begin
                // Expiry has priority over a same-cycle prog_req
                if (tmr_exp) begin
                    state_d = ST_IDLE;
                end else if (prog_req) begin
                    state_d  = ST_PROGRAM;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                end
            end
            ST_PROGRAM: begin
                if (key_valid) begin
                    if (key_digit == CANCEL_DIGIT) begin
                        state_d = ST_IDLE;
                    end else begin
                        shadow_d[4*int'(idx_q) +: 4] = key_digit;
                        if (idx_q == LAST_IDX) begin
                            // Whole code committed at once, never partially
                            code_d  = shadow_d;
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            idx_d    = idx_q + IDX_W'(1);
                            tmr_load = 1'b1;
                        end
                    end
                end else if (tmr_exp) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_exp) begin
                    fcnt_d  = 4'd0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef LOCK_AUDIT_EN
    logic [7:0] ftot_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ftot_q <= 8'd0;
        end else if (fail_d && ftot_q != 8'hFF) begin
            ftot_q <= ftot_q + 8'd1;
        end
    end
    assign fail_total = ftot_q;
`endif

    // Status outputs are registered from the current state, so they
    // trail state_o by one cycle but keep the exact hold lengths.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            code_q   <= DEFAULT_CODE;
            shadow_q <= '0;
            idx_q    <= '0;
            mis_q    <= 1'b0;
            fcnt_q   <= 4'd0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            mis_q    <= mis_d;
            fcnt_q   <= fcnt_d;
            unlock_q <= (state_q == ST_UNLOCKED) ||
                        (state_q == ST_PROGRAM);
            locked_q <= (state_q == ST_LOCKOUT);
            fail_q   <= fail_d;
            done_q   <= done_d;
        end
    end

    assign unlock     = unlock_q;
    assign locked_out = locked_q;
    assign fail_pulse = fail_q;
    assign prog_done  = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_lock_sequencer.sv
// Self-checking bench for lock_sequencer: event scoreboard plus state checks.
// Stored code digit 0 is bits [3:0], so default 16'h1234 is keyed as 4,3,2,1.
module tb_lock_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       prog_req = 1'b0;
    logic       unlock, locked_out, fail_pulse, prog_done;
    logic [2:0] state_o;
`ifdef LOCK_AUDIT_EN
    logic [7:0] fail_total;
`endif

    lock_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .prog_req  (prog_req),
        .unlock    (unlock),
        .locked_out(locked_out),
        .fail_pulse(fail_pulse),
        .prog_done (prog_done),
        .state_o   (state_o)
`ifdef LOCK_AUDIT_EN
        ,
        .fail_total(fail_total)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kinds: 1 unlock rise, 2 unlock fall, 3 lockout rise,
    //        4 lockout fall, 5 fail_pulse high, 6 prog_done high
    typedef struct packed { int kind; int at; } ev_t;
    ev_t expq[$];
    ev_t obsq[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  last_edge = 0;
    logic p_unl = 1'b0, p_lck = 1'b0;

    function automatic ev_t mk(input int k, input int a);
        ev_t e;
        e.kind = k;
        e.at   = a;
        return e;
    endfunction

    always @(negedge clk) begin
        if (unlock && !p_unl) obsq.push_back(mk(1, cyc));
        if (!unlock && p_unl) obsq.push_back(mk(2, cyc));
        if (locked_out && !p_lck) obsq.push_back(mk(3, cyc));
        if (!locked_out && p_lck) obsq.push_back(mk(4, cyc));
        if (fail_pulse) obsq.push_back(mk(5, cyc));
        if (prog_done) obsq.push_back(mk(6, cyc));
        p_unl <= unlock;
        p_lck <= locked_out;
    end

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
        last_edge = cyc;
    endtask

    task automatic press4(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input logic [3:0] d);
        key(a);
        key(b);
        key(c);
        key(d);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic test_reset();
        idle(2);
        n_cmp++;
        if ({unlock, locked_out, fail_pulse, prog_done} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_outs: got %b want 0000",
                     {unlock, locked_out, fail_pulse, prog_done});
        end
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: got %0d want 0", state_o);
        end
        rst = 1'b1;
        idle(2);
        n_cmp++;
        if (state_o !== 3'd0 || unlock !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got st %0d unl %b want 0 0",
                     state_o, unlock);
        end
`ifdef LOCK_AUDIT_EN
        n_cmp++;
        if (fail_total !== 8'd0) begin
            n_err++;
            $display("FAIL reset_total: got %0d want 0", fail_total);
        end
`endif
    endtask

    task automatic test_unlock();
        int n;
        ev_t e, o;
        press4(4, 3, 2, 1);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        expq.push_back(mk(2, n + 258));
        n_cmp++;
        if (state_o !== 3'd2) begin
            n_err++;
            $display("FAIL unl_check_st: got %0d want 2", state_o);
        end
        idle(1);
        n_cmp++;
        if (state_o !== 3'd3) begin
            n_err++;
            $display("FAIL unl_state: got %0d want 3", state_o);
        end
        idle(262);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL unlock evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL unlock ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_lockout();
        int n, m;
        ev_t e, o;
        press4(1, 2, 3, 4);
        expq.push_back(mk(5, last_edge + 1));
        idle(3);
        press4(4, 3, 2, 5);
        expq.push_back(mk(5, last_edge + 1));
        idle(3);
        press4(4, 3, 2, 5);
        n = last_edge;
        expq.push_back(mk(5, n + 1));
        expq.push_back(mk(3, n + 2));
        expq.push_back(mk(4, n + 1026));
        idle(5);
        press4(4, 3, 2, 1);
        idle(2);
        n_cmp++;
        if (state_o !== 3'd5) begin
            n_err++;
            $display("FAIL lk_state: got %0d want 5", state_o);
        end
        wait_until(n + 1030);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL lk_exit: got %0d want 0", state_o);
        end
        press4(4, 3, 2, 1);
        m = last_edge;
        expq.push_back(mk(1, m + 2));
        expq.push_back(mk(2, m + 258));
        idle(262);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL lockout evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL lockout ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_cancel_timeout();
        int n;
        ev_t e, o;
        key(4);
        key(3);
        key(4'hF);
        idle(1);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL cancel_st: got %0d want 0", state_o);
        end
        key(4);
        key(3);
        n = last_edge;
        wait_until(n + 4095);
        n_cmp++;
        if (state_o !== 3'd1) begin
            n_err++;
            $display("FAIL to_edge_st: got %0d want 1", state_o);
        end
        idle(1);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL to_st: got %0d want 0", state_o);
        end
        idle(3);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL cancel evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL cancel ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_program();
        int n, p;
        ev_t e, o;
        press4(4, 3, 2, 1);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        wait_until(n + 2);
        prog_req = 1'b1;
        idle(1);
        prog_req = 1'b0;
        n_cmp++;
        if (state_o !== 3'd4) begin
            n_err++;
            $display("FAIL prog_st: got %0d want 4", state_o);
        end
        press4(9, 8, 7, 6);
        p = last_edge;
        expq.push_back(mk(6, p));
        expq.push_back(mk(2, p + 1));
        idle(3);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL prog_end_st: got %0d want 0", state_o);
        end
        press4(4, 3, 2, 1);
        expq.push_back(mk(5, last_edge + 1));
        idle(3);
        press4(9, 8, 7, 6);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        expq.push_back(mk(2, n + 258));
        idle(262);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL program evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL program ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_prog_cancel();
        int n;
        ev_t e, o;
        key(9);
        key(8);
        rst = 1'b0;
        idle(1);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL midrst_st: got %0d want 0", state_o);
        end
        rst = 1'b1;
        idle(1);
        press4(4, 3, 2, 1);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        wait_until(n + 2);
        prog_req = 1'b1;
        idle(1);
        prog_req = 1'b0;
        key(5);
        key(5);
        key(4'hF);
        expq.push_back(mk(2, last_edge + 1));
        idle(3);
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL pcancel_st: got %0d want 0", state_o);
        end
        press4(4, 3, 2, 1);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        expq.push_back(mk(2, n + 258));
        wait_until(n + 256);
        prog_req = 1'b1;
        idle(1);
        prog_req = 1'b0;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL expiry_prog_st: got %0d want 0", state_o);
        end
        idle(4);
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL pcancel evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pcancel ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    task automatic test_back_to_back();
        int n;
        ev_t e, o;
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        idle(1);
        for (int i = 0; i < 2; i++) begin
            press4(4, 3, 2, 5);
            expq.push_back(mk(5, last_edge + 1));
            idle(3);
        end
        press4(4, 3, 2, 1);
        n = last_edge;
        expq.push_back(mk(1, n + 2));
        expq.push_back(mk(2, n + 258));
        idle(262);
        for (int i = 0; i < 2; i++) begin
            press4(4, 3, 2, 5);
            expq.push_back(mk(5, last_edge + 1));
            idle(3);
        end
        n_cmp++;
        if (state_o !== 3'd0 || locked_out !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_nolock: got st %0d lk %b want 0 0",
                     state_o, locked_out);
        end
`ifdef LOCK_AUDIT_EN
        n_cmp++;
        if (fail_total !== 8'd4) begin
            n_err++;
            $display("FAIL fail_total: got %0d want 4", fail_total);
        end
`endif
        n_cmp++;
        if (obsq.size() != expq.size()) begin
            n_err++;
            $display("FAIL b2b evcount: got %0d want %0d",
                     obsq.size(), expq.size());
        end
        while (expq.size() > 0 && obsq.size() > 0) begin
            e = expq.pop_front();
            o = obsq.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL b2b ev: got k%0d @%0d want k%0d @%0d",
                         o.kind, o.at, e.kind, e.at);
            end
        end
        expq.delete();
        obsq.delete();
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_lockout();
        test_cancel_timeout();
        test_program();
        test_prog_cancel();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
